// File: rtl/fib_blink_decoder.sv
// Receive-side decoder for the Fibonacci LED blinker: measures synchronised high/low phases and
// reports each pulse group as one value. Define FIB_DEC_SEQ_CHECK_EN to build the Fibonacci checker.
module fib_blink_decoder #(
    parameter int DATA_WIDTH  = 4,
    parameter int TIMER_WIDTH = 13,
    parameter int MIN_HIGH    = 800,
    parameter int GAP_LOW     = 4000
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  led_in,
    output logic [DATA_WIDTH-1:0] value_out,
    output logic                  valid_out,
    output logic                  glitch_out,
    output logic                  ovf_out,
    output logic                  seq_err_out,
    output logic [1:0]            state_out
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_UNUSED = 2'd3
    } state_e;

    localparam logic [TIMER_WIDTH-1:0] CNT_ZERO_C   = {TIMER_WIDTH{1'b0}};
    localparam logic [TIMER_WIDTH-1:0] CNT_ONE_C    = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMER_WIDTH-1:0] CNT_MAX_C    = {TIMER_WIDTH{1'b1}};
    localparam logic [TIMER_WIDTH-1:0] MIN_HIGH_C   = TIMER_WIDTH'(MIN_HIGH);
    localparam logic [TIMER_WIDTH-1:0] GAP_LOW_C    = TIMER_WIDTH'(GAP_LOW);
    localparam logic [DATA_WIDTH-1:0]  PULSE_ZERO_C = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]  PULSE_ONE_C  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  PULSE_MAX_C  = {DATA_WIDTH{1'b1}};

    function automatic logic [TIMER_WIDTH-1:0] cnt_sat_inc(input logic [TIMER_WIDTH-1:0] v);
        if (v == CNT_MAX_C) begin
            return v;
        end else begin
            return v + CNT_ONE_C;
        end
    endfunction

    logic [1:0]            rst_sync_r;
    logic                  rst_n_s;
    logic                  led_meta_r;
    logic                  led_s_r;
    state_e                state_r;
    state_e                state_nxt_s;
    logic [TIMER_WIDTH-1:0] cnt_r;
    logic [TIMER_WIDTH-1:0] cnt_nxt_s;
    logic [DATA_WIDTH-1:0] pulse_cnt_r;
    logic [DATA_WIDTH-1:0] pulse_cnt_nxt_s;
    logic                  emit_s;
    logic                  glitch_s;
    logic                  sat_s;
    logic                  seq_err_s;

    // Reset bridge: asserts asynchronously, releases on the clock
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Two-flop synchroniser for the asynchronous blink line
    always_ff @(posedge clock_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            led_meta_r <= 1'b0;
            led_s_r    <= 1'b0;
        end else begin
            led_meta_r <= led_in;
            led_s_r    <= led_meta_r;
        end
    end

    // FSM, phase timer and pulse counter registers
    always_ff @(posedge clock_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO_C;
            pulse_cnt_r <= PULSE_ZERO_C;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pulse_cnt_r <= pulse_cnt_nxt_s;
        end
    end

    // Phase classification: a low phase that survives to GAP_LOW closes the group,
    // but a rising edge arriving in that same cycle keeps the group open
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        pulse_cnt_nxt_s = pulse_cnt_r;
        emit_s          = 1'b0;
        glitch_s        = 1'b0;
        sat_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (led_s_r) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ONE_C;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (led_s_r) begin
                    cnt_nxt_s = cnt_sat_inc(cnt_r);
                end else begin
                    if (cnt_r >= MIN_HIGH_C) begin
                        if (pulse_cnt_r == PULSE_MAX_C) begin
                            sat_s = 1'b1;
                        end else begin
                            pulse_cnt_nxt_s = pulse_cnt_r + PULSE_ONE_C;
                        end
                    end else begin
                        glitch_s = 1'b1;
                    end
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = CNT_ONE_C;
                end
            end
            ST_LOW: begin
                if (led_s_r) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ONE_C;
                end else begin
                    cnt_nxt_s = cnt_sat_inc(cnt_r);
                    if (cnt_nxt_s == GAP_LOW_C) begin
                        state_nxt_s = ST_IDLE;
                        if (pulse_cnt_r != PULSE_ZERO_C) begin
                            emit_s          = 1'b1;
                            pulse_cnt_nxt_s = PULSE_ZERO_C;
                        end else begin
                            emit_s = 1'b0;
                        end
                    end else begin
                        state_nxt_s = ST_LOW;
                    end
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                cnt_nxt_s       = CNT_ZERO_C;
                pulse_cnt_nxt_s = PULSE_ZERO_C;
            end
        endcase
    end

`ifdef FIB_DEC_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_a_r;
    logic [DATA_WIDTH-1:0] exp_b_r;

    // Expected Fibonacci terms; advances on every emitted value, never resynchronises
    always_ff @(posedge clock_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            exp_a_r <= PULSE_ZERO_C;
            exp_b_r <= PULSE_ONE_C;
        end else if (emit_s) begin
            exp_a_r <= exp_b_r;
            exp_b_r <= exp_a_r + exp_b_r;
        end else begin
            exp_a_r <= exp_a_r;
            exp_b_r <= exp_b_r;
        end
    end

    assign seq_err_s = emit_s & (pulse_cnt_r != exp_b_r);
`else
    assign seq_err_s = 1'b0;
`endif

    // Registered reporting outputs
    always_ff @(posedge clock_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            value_out   <= PULSE_ZERO_C;
            valid_out   <= 1'b0;
            glitch_out  <= 1'b0;
            ovf_out     <= 1'b0;
            seq_err_out <= 1'b0;
        end else begin
            valid_out   <= emit_s;
            glitch_out  <= glitch_s;
            seq_err_out <= seq_err_s;
            if (emit_s) begin
                value_out <= pulse_cnt_r;
            end else begin
                value_out <= value_out;
            end
            if (sat_s) begin
                ovf_out <= 1'b1;
            end else begin
                ovf_out <= ovf_out;
            end
        end
    end

    assign state_out = state_r;

endmodule
